mul16_accel: RTL
================

Name: mul16_accel

Overview:
- Hardware responder for the double-precision two's-complement multiply task.
- Sits beside the byte-wide data memory and answers the start/done handshake issued by the test driver.
- Reads 16 pairs of signed 16-bit operands from data memory and computes 16 signed 32-bit products.
- Writes the products back to data memory, then raises done.

Parameters:
- NUM_PAIRS, 16: operand pairs processed per run.
- SRC_BASE, 0: byte address of the first operand byte.
- DST_BASE, 64: byte address of the first product byte.
- AW, 8: data memory address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request from driver. Held high while memory is loaded; a high-to-low transition launches a run.
- done  out  1  acknowledge; high when all products are written.
- busy  out  1  high while a run is in progress.
- mem_addr  out  AW  data memory byte address.
- mem_rd_data  in  8  data memory read data, combinational from mem_addr in the same cycle.
- mem_wr_en  out  1  data memory write strobe, written at the rising edge.
- mem_wr_data  out  8  write byte.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; start_q=0; pair index=0.
  - done=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
  - All outputs clear immediately, not at the next edge.
- Start detect:
  - start_q registers start every cycle.
  - Launch when state=IDLE and start_q=1 and start=0.
  - Because start_q resets to 0, a start that is already low at reset release does not launch; start must go high then low.
- Memory layout, pair j = 0..NUM_PAIRS-1, all big-endian:
  - Operand A = {mem[SRC_BASE+4j], mem[SRC_BASE+4j+1]}.
  - Operand B = {mem[SRC_BASE+4j+2], mem[SRC_BASE+4j+3]}.
  - Product P = A*B, stored MSB first at DST_BASE+4j .. DST_BASE+4j+3.
- States:
  - IDLE → RD0 on launch.
  - RD0..RD3: one byte read per cycle into A_hi, A_lo, B_hi, B_lo.
  - MUL: exactly 16 cycles, iterative; any radix-2 scheme is allowed.
  - WR0..WR3: mem_wr_en=1, write P[31:24], P[23:16], P[15:8], P[7:0] to consecutive addresses.
  - NEXT: mem_wr_en=0. If j=NUM_PAIRS-1 go to DONE, else increment j and go to RD0.
  - DONE: done=1. Go to IDLE (done=0) at the first edge where start=1. Done is high at least one cycle.
- Latency:
  - 25 cycles per pair.
  - done registers high NUM_PAIRS*25+1 = 401 edges after the launch edge.
  - busy is high from the launch edge until entry to DONE.
- Arithmetic:
  - Exact signed product of sign-extended 16-bit operands; always fits in 32 bits.
  - -32768*-32768 = 0x40000000.
  - Zero and sign combinations need no special-casing.
- Memory access rules:
  - mem_wr_en is asserted only in WR0..WR3.
  - Source bytes are never written.
  - No access outside SRC_BASE..SRC_BASE+4*NUM_PAIRS-1 and DST_BASE..DST_BASE+4*NUM_PAIRS-1.
- Boundary cases:
  - start rising mid-run: ignored, the run completes. On entering DONE with start already high, done pulses exactly one cycle.
  - A start fall during a run is not queued.
  - Async reset mid-run aborts the run. Bytes already written stay in memory; there are no further writes.
  - Back-to-back runs without reset are allowed; each run fully overwrites the destination area.

Test Plan:
- Reset defaults:
  - Stimulus: assert rst_n=0 with start=1; release.
  - Required: done=0, busy=0, mem_wr_en=0 throughout.
  - Required: holding start low with no prior high causes no launch in 500 cycles.
- Mixed signs:
  - Stimulus: pair0 A=0x0003, B=0xFFFB; pair1 A=0x0000, B=0x7FFF; rest A=0x0002, B=0x0002.
  - Required: mem[64..67]=FF FF FF F1; mem[68..71]=00 00 00 00; every other product = 00 00 00 04.
- Extremes:
  - Stimulus: pair0 A=0x8000, B=0x8000; pair1 A=0x7FFF, B=0x8000; pair2 A=0xFFFF, B=0xFFFF; pair15 A=0x7FFF, B=0x7FFF.
  - Required: mem[64..67]=40 00 00 00; mem[68..71]=C0 00 80 00; mem[72..75]=00 00 00 01; mem[124..127]=3F FF 00 01.
- Handshake timing:
  - Stimulus: start high for 3 cycles, then low.
  - Required: busy rises at the launch edge; done is low for 400 edges and rises at edge 401; done stays high while start is low.
  - Required: after start goes high, done=0 at the next edge; mem[0..63] is unchanged.
- Restart:
  - Stimulus: after run 1, load 10 random operand sets in turn; start high then low for each.
  - Required: every product matches the 32-bit signed reference model; done is low again before each launch.
- Abort:
  - Stimulus: drop rst_n for 2 cycles, 100 cycles into a run.
  - Required: busy/done/mem_wr_en drop immediately; no writes after reset; a following start fall runs to a full, correct completion.

Source files
------------

// File: rtl/mul16_accel_if.sv
// Start/done handshake and byte-wide data memory port of the 16x16 signed multiply responder.
// The master drives start and the read data; the slave (accelerator) drives everything else.
interface mul16_accel_if #(
  parameter int unsigned AW = 8
);
  logic          start;
  logic          done;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;

  modport master (
    output start,
    output mem_rd_data,
    input  done,
    input  busy,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data
  );

  modport slave (
    input  start,
    input  mem_rd_data,
    output done,
    output busy,
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data
  );
endinterface

// File: rtl/mul16_accel.sv
// Reads NUM_PAIRS big-endian signed 16-bit operand pairs from data memory, multiplies each
// with a 16-cycle shift-add loop and writes the 32-bit products back big-endian.
module mul16_accel #(
  parameter int unsigned NUM_PAIRS = 16,
  parameter int unsigned SRC_BASE  = 0,
  parameter int unsigned DST_BASE  = 64,
  parameter int unsigned AW        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mul16_accel_if.slave      bus
);

  localparam int unsigned JW         = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int unsigned CW         = 4;
  localparam int unsigned MUL_CYCLES = 16;
  localparam logic [JW-1:0] LAST_PAIR = JW'(NUM_PAIRS - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(MUL_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, RD3, MUL, WR0, WR1, WR2, WR3, NEXT, DONE
  } state_e;

  state_e          state_q,   state_d;
  logic            start_q,   start_d;
  logic [JW-1:0]   j_q,       j_d;
  logic [15:0]     a_q,       a_d;
  logic [7:0]      b_hi_q,    b_hi_d;
  logic [31:0]     mcand_q,   mcand_d;
  logic [15:0]     mplier_q,  mplier_d;
  logic [31:0]     acc_q,     acc_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic            done_q,    done_d;
  logic            busy_q,    busy_d;
  logic            wr_en_q,   wr_en_d;
  logic [AW-1:0]   addr_q,    addr_d;
  logic [7:0]      wr_data_q, wr_data_d;

  logic [31:0]     addend_c;
  logic [31:0]     acc_nx_c;

  // Byte address of the first byte of pair j inside an area starting at base.
  function automatic logic [AW-1:0] pair_addr(input int unsigned base, input logic [JW-1:0] j);
    return AW'(base + (32'(j) << 2));
  endfunction

  always_comb begin
    state_d   = state_q;
    start_d   = bus.start;
    j_d       = j_q;
    a_d       = a_q;
    b_hi_d    = b_hi_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    busy_d    = busy_q;
    wr_en_d   = wr_en_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;

    // Multiplier bit 15 carries weight -2^15, so the final partial product is subtracted.
    addend_c = mplier_q[0] ? mcand_q : 32'd0;
    acc_nx_c = (cnt_q == LAST_STEP) ? (acc_q - addend_c) : (acc_q + addend_c);

    unique case (state_q)
      IDLE: begin
        if (start_q && !bus.start) begin
          state_d = RD0;
          busy_d  = 1'b1;
          j_d     = '0;
          addr_d  = pair_addr(SRC_BASE, '0);
        end
      end
      RD0: begin
        a_d[15:8] = bus.mem_rd_data;
        addr_d    = addr_q + AW'(1);
        state_d   = RD1;
      end
      RD1: begin
        a_d[7:0] = bus.mem_rd_data;
        addr_d   = addr_q + AW'(1);
        state_d  = RD2;
      end
      RD2: begin
        b_hi_d  = bus.mem_rd_data;
        addr_d  = addr_q + AW'(1);
        state_d = RD3;
      end
      RD3: begin
        mcand_d  = {{16{a_q[15]}}, a_q};
        mplier_d = {b_hi_q, bus.mem_rd_data};
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = MUL;
      end
      MUL: begin
        acc_d    = acc_nx_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d   = WR0;
          wr_en_d   = 1'b1;
          addr_d    = pair_addr(DST_BASE, j_q);
          wr_data_d = acc_nx_c[31:24];
        end
      end
      WR0: begin
        addr_d    = addr_q + AW'(1);
        wr_data_d = acc_q[23:16];
        state_d   = WR1;
      end
      WR1: begin
        addr_d    = addr_q + AW'(1);
        wr_data_d = acc_q[15:8];
        state_d   = WR2;
      end
      WR2: begin
        addr_d    = addr_q + AW'(1);
        wr_data_d = acc_q[7:0];
        state_d   = WR3;
      end
      WR3: begin
        wr_en_d = 1'b0;
        state_d = NEXT;
      end
      NEXT: begin
        if (j_q == LAST_PAIR) begin
          state_d = DONE;
          busy_d  = 1'b0;
          addr_d  = '0;
        end else begin
          j_d     = j_q + JW'(1);
          addr_d  = pair_addr(SRC_BASE, j_q + JW'(1));
          state_d = RD0;
        end
      end
      DONE: begin
        // done must be seen high for a cycle before start may retire it.
        done_d = 1'b1;
        if (bus.start && done_q) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      j_q       <= '0;
      a_q       <= '0;
      b_hi_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      j_q       <= j_d;
      a_q       <= a_d;
      b_hi_q    <= b_hi_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wr_data_q;

endmodule
